// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction handshake and completion status between source and sequencer
interface alu_op_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] acc;
    logic       carry_flag;
    logic       zero_flag;
    logic       result_valid;
    logic       illegal_op;
    modport master (
        output instr_valid, opcode, operand,
        input  instr_ready, acc, carry_flag, zero_flag, result_valid, illegal_op
    );
    modport slave (
        input  instr_valid, opcode, operand,
        output instr_ready, acc, carry_flag, zero_flag, result_valid, illegal_op
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one-hot ALU strobes per opcode and writes results back to a 4-bit accumulator
module alu_op_sequencer (
    input  logic                     clk_i,
    input  logic                     reset_i,
    alu_op_sequencer_if.slave        bus,
    output logic                     add_o,
    output logic                     sub_o,
    output logic                     lsr_o,
    output logic                     lsh_o,
    output logic                     rsh_o,
    output logic                     and_o,
    output logic                     or_o,
    output logic                     xor_o,
    output logic                     inv_o,
    output logic                     clr_o,
    output logic [3:0]               alu_in1_o,
    output logic [3:0]               alu_in2_o,
    input  logic [3:0]               alu_out_i,
    input  logic                     alu_overflow_i,
    input  logic                     alu_shift_flag_i
);
    typedef enum logic [2:0] {IDLE, EXEC, SH_LOAD, SH_EXEC, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] op_q, op_d, opd_q, opd_d, acc_q, acc_d;
    logic       carry_q, carry_d, zero_q, zero_d;
    logic       ex;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            opd_q   <= 4'h0;
            acc_q   <= 4'h0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (bus.instr_valid) begin
                op_d    = bus.opcode;
                opd_d   = bus.operand;
                state_d = (bus.opcode == 4'h9 || bus.opcode == 4'hA) ? SH_LOAD : EXEC;
            end
            EXEC: begin
                // NOP and illegal opcodes leave acc and both flags untouched
                if (op_q inside {[4'h1:4'h8]}) begin
                    acc_d   = (op_q == 4'h1) ? opd_q : alu_out_i;
                    carry_d = (op_q == 4'h2 || op_q == 4'h3) ? alu_overflow_i : 1'b0;
                    zero_d  = (acc_d == 4'h0);
                end
                state_d = DONE;
            end
            SH_LOAD: state_d = SH_EXEC;
            SH_EXEC: begin
                acc_d   = alu_out_i;
                carry_d = alu_shift_flag_i;
                zero_d  = (alu_out_i == 4'h0);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign ex    = (state_q == EXEC);
    assign add_o = ex && op_q == 4'h2;
    assign sub_o = ex && op_q == 4'h3;
    assign and_o = ex && op_q == 4'h4;
    assign or_o  = ex && op_q == 4'h5;
    assign xor_o = ex && op_q == 4'h6;
    assign inv_o = ex && op_q == 4'h7;
    assign clr_o = ex && op_q == 4'h8;
    assign lsr_o = (state_q == SH_LOAD);
    assign lsh_o = (state_q == SH_EXEC) && op_q == 4'h9;
    assign rsh_o = (state_q == SH_EXEC) && op_q == 4'hA;
    assign alu_in1_o        = acc_q;
    assign alu_in2_o        = opd_q;
    assign bus.instr_ready  = (state_q == IDLE) && !reset_i;
    assign bus.acc          = acc_q;
    assign bus.carry_flag   = carry_q;
    assign bus.zero_flag    = zero_q;
    assign bus.result_valid = (state_q == DONE);
    assign bus.illegal_op   = (state_q == DONE) && op_q > 4'hA;
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that drives the one-hot control strobes and operands of the 4-bit ALU and consumes its result and flags. It accepts one opcode/operand pair per transaction over a valid/ready handshake, sequences the required strobes (including the two-step load-then-shift for shifts), writes the ALU result back into a 4-bit accumulator and reports completion with carry/zero/illegal status. It sits between the instruction source and the ALU, and is the only block permitted to assert ALU control lines.

## Interface
- No parameters; all datapaths are fixed at 4 bits.
- clk  in  1  system clock; everything is registered on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  opcode/operand present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- opcode  in  4  0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 INV, 8 CLR, 9 LSH, A RSH, B–F illegal.
- operand  in  4  second operand (LDA load value).
- ADD, SUB, LSR, LSH, RSH, AND, OR, XOR, INV, CLR  out  1 each  ALU strobes; at most one high per cycle, except that LSR is never high together with LSH/RSH.
- alu_in1  out  4  equals acc.
- alu_in2  out  4  equals the latched operand register.
- alu_out  in  4  ALU result.
- alu_overflow  in  1  ALU add/sub carry/borrow.
- alu_shift_flag  in  1  ALU shifted-out bit.
- acc  out  4  accumulator.
- carry_flag  out  1  registered carry/borrow/shift-out.
- zero_flag  out  1  high when acc == 0 after the last writeback.
- result_valid  out  1  one-cycle completion pulse.
- illegal_op  out  1  high with result_valid for opcodes B–F.

## Operation
- States: IDLE, EXEC, SH_LOAD, SH_EXEC, DONE.
- IDLE: instr_ready=1. When instr_valid is high, the handshake fires: opcode and operand are latched into op_r/opd_r. Transition:
  - 9/A → SH_LOAD.
  - All others → EXEC.
- EXEC, for op_r:
  - 2–8: assert the matching strobe for exactly this cycle. At the end of the cycle: acc←alu_out.
  - ADD/SUB: carry_flag←alu_overflow.
  - AND/OR/XOR/INV/CLR: carry_flag←0.
  - LDA: no strobe; acc←opd_r, carry_flag←0.
  - NOP: no strobe; acc and flags unchanged.
  - Illegal: no strobe; acc and flags unchanged; illegal flag set.
  - All cases → DONE.
- SH_LOAD: assert LSR only, so the ALU shift register captures acc at this edge → SH_EXEC.
- SH_EXEC: assert LSH (op 9) or RSH (op A), with LSR low. At the end of the cycle: acc←alu_out, carry_flag←alu_shift_flag → DONE.
- DONE:
  - result_valid=1 for one cycle; illegal_op=1 if the opcode was illegal.
  - zero_flag reflects the updated acc; it is recomputed for every opcode except NOP/illegal.
  - → IDLE.
- All strobes decode from registered state/op_r only; no combinational path exists from instr_valid, opcode or operand to the strobes.
- An instr_valid outside IDLE is ignored; the source must hold it until instr_ready.

## Timing
- Reset: state=IDLE, acc=0, op_r=0, opd_r=0, all strobes=0, carry_flag=0, zero_flag=1, result_valid=0, illegal_op=0, instr_ready=0 while reset is asserted.
- instr_ready=1 in the first cycle after reset deasserts.
- Handshake at edge T:
  - Non-shift: EXEC in cycle T+1, acc updated at the end of T+1, result_valid in T+2, IDLE in T+3.
  - Shift: SH_LOAD in T+1, SH_EXEC in T+2, result_valid in T+3.
- Throughput: one operation per 3 cycles (4 for shifts); back-to-back accept is allowed in the IDLE cycle directly after DONE.
- Arithmetic wraps modulo 16:
  - ADD: F+1 → acc=0, carry=1, zero=1.
  - SUB: 0−1 → acc=F, carry(borrow)=1.
- Reset in any state forces the reset values at the next edge; an in-flight operation is discarded, with no result_valid and no strobe in the following cycle.
- If instr_valid is high during reset, no acceptance occurs until the first IDLE cycle.

## Test plan
- Reset, then LDA 5 → result_valid 2 cycles after accept; acc=5, carry=0, zero=0; no strobe ever asserted.
- LDA F, ADD 1 → ADD high for exactly one cycle with alu_in1=F and alu_in2=1; acc=0, carry=1, zero=1.
- LDA 0, SUB 1 → acc=F, carry=1; then XOR F → acc=0, carry=0, zero=1.
- LDA 9, LSH → LSR for one cycle, then LSH for one cycle (never overlapping); acc=2, carry=1, result_valid 3 cycles after accept; then RSH → acc=1, carry=0.
- Opcode C → illegal_op and result_valid together; acc and flags unchanged; no strobe asserted; sequencer returns to IDLE and accepts NOP next.
- Assert reset during SH_EXEC → next cycle all strobes 0, acc=0, zero=1, no result_valid; instr_ready=1 the cycle after reset drops.
